// File: rtl/i2s_rx_sequencer.sv
// I2S receive sequencer: frames sck/ws/sd into stereo pairs and raises sticky overrun/framing flags.
// Define I2S_RX_LJ_FORMAT_EN for left-justified capture (no one-bit delay after ws changes).
module i2s_rx_sequencer #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                sck,
  input  logic                ws,
  input  logic                sd,
  input  logic                out_ready,
  input  logic                err_clr,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                overrun,
  output logic                frame_err,
  output logic [1:0]          state_dbg
);

  // Output handshake: a frame transfers on every clk edge where out_valid && out_ready;
  // out_valid and the data stay stable until that edge.

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam logic [5:0] SLOT_LAST = 6'(SLOT_W - 1);
`ifdef I2S_RX_LJ_FORMAT_EN
  localparam logic [6:0] CAP_LIM = 7'(SAMPLE_W - 1);
`else
  localparam logic [6:0] CAP_LIM = 7'(SAMPLE_W);
`endif

  state_t              state, state_nxt;
  logic                sck_d;
  logic                ws_prev;
  logic [5:0]          bit_cnt;
  logic [SAMPLE_W-1:0] shift_reg;
  logic [SAMPLE_W-1:0] left_hold;
  logic                rise, ws_chg, slot_ok, capture;
  logic                latch_left, complete, err_set;

  assign rise    = sck & ~sck_d;
  assign ws_chg  = rise & (ws != ws_prev);
  assign slot_ok = (bit_cnt == SLOT_LAST);
  // bit_cnt still holds the previous bit's index, so bit_cnt+1 is the index of this bit
  assign capture = rise & ~ws_chg & ({1'b0, bit_cnt} < CAP_LIM);
  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    latch_left = 1'b0;
    complete   = 1'b0;
    err_set    = 1'b0;
    case (state)
      SYNC: begin
        if (rise && ws_prev && !ws) state_nxt = LEFT;
      end
      LEFT: begin
        if (ws_chg) begin
          if (!slot_ok) begin
            err_set   = 1'b1;
            state_nxt = SYNC;
          end else begin
            latch_left = 1'b1;
            state_nxt  = RIGHT;
          end
        end
      end
      RIGHT: begin
        if (ws_chg) begin
          if (!slot_ok) begin
            err_set   = 1'b1;
            state_nxt = SYNC;
          end else begin
            complete  = 1'b1;
            state_nxt = LEFT;
          end
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= SYNC;
      sck_d     <= 1'b0;
      ws_prev   <= 1'b1;
      bit_cnt   <= 6'd0;
      shift_reg <= '0;
      left_hold <= '0;
    end else begin
      state <= state_nxt;
      sck_d <= sck;
      if (rise) begin
        ws_prev <= ws;
        if (ws_chg)                bit_cnt <= 6'd0;
        else if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
      end
      if (ws_chg) begin
`ifdef I2S_RX_LJ_FORMAT_EN
        shift_reg <= SAMPLE_W'(sd);
`else
        shift_reg <= '0;
`endif
      end else if (capture) begin
        shift_reg <= (shift_reg << 1) | SAMPLE_W'(sd);
      end
      if (latch_left) left_hold <= shift_reg;
    end
  end

  // A completion during a stalled transfer is dropped; one coinciding with an accept replaces it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_left  <= left_hold;
          out_right <= shift_reg;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (complete && out_valid && !out_ready) overrun <= 1'b1;
      else if (err_clr)                        overrun <= 1'b0;
      if (err_set)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Directed bench for i2s_rx_sequencer: bit-level I2S driver, frame scoreboard, sticky-flag checks.
module tb_i2s_rx_sequencer;
  localparam int SW = 24;
`ifdef I2S_RX_LJ_FORMAT_EN
  localparam bit LJ_BUILD = 1'b1;
`else
  localparam bit LJ_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn, sck, ws, sd, out_ready, err_clr;
  logic          out_valid, overrun, frame_err;
  logic [SW-1:0] out_left, out_right;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail = 0;
  int accepted = 0;
  int valid_cycles = 0;
  logic [2*SW-1:0] exp_q[$];
  logic [2*SW-1:0] mon_exp;
  logic [2*SW-1:0] lj_exp;

  // clock / reset
  always #5 clk = ~clk;

  i2s_rx_sequencer #(.SAMPLE_W(SW), .SLOT_W(32)) dut (
    .clk(clk), .resetn(resetn), .sck(sck), .ws(ws), .sd(sd),
    .out_ready(out_ready), .err_clr(err_clr), .out_valid(out_valid),
    .out_left(out_left), .out_right(out_right), .overrun(overrun),
    .frame_err(frame_err), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one sck period is 8 clk, ws/sd change while sck is low
  task automatic send_bit(input logic w, input logic d, input bit acc);
    @(negedge clk);
    sck = 1'b0; ws = w; sd = d;
    repeat (3) @(negedge clk);
    @(negedge clk);
    sck = 1'b1;
    if (acc) out_ready = 1'b1;
    @(negedge clk);
    if (acc) out_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic bitval(input logic [SW-1:0] w, input int idx, input bit lj, input bit zfill);
    logic junk;
    junk = zfill ? 1'b0 : 1'($urandom_range(0, 1));
    if (lj) return (idx < SW) ? w[SW-1-idx] : junk;
    return (idx >= 1 && idx <= SW) ? w[SW-idx] : junk;
  endfunction

  task automatic slot(input logic w, input logic [SW-1:0] word, input int first, input int last,
                      input bit lj, input bit zfill);
    for (int i = first; i <= last; i++) send_bit(w, bitval(word, i, lj, zfill), 1'b0);
  endtask

  // rest of left slot, full right slot, then bit 0 of the next left slot (completes the frame)
  task automatic frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic [SW-1:0] ln);
    slot(1'b0, l, 1, 31, LJ_BUILD, 1'b0);
    slot(1'b1, r, 0, 31, LJ_BUILD, 1'b0);
    slot(1'b0, ln, 0, 0, LJ_BUILD, 1'b0);
  endtask

  // scoreboard: every accepted transfer is compared with the oldest expected frame
  always begin
    @(negedge clk);
    #1;
    if (resetn === 1'b1 && out_valid === 1'b1) begin
      valid_cycles++;
      if (out_ready === 1'b1) begin
        check("frame_expected", 48'(exp_q.size() != 0), 48'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("out_left", 48'(out_left), 48'(mon_exp[2*SW-1:SW]));
          check("out_right", 48'(out_right), 48'(mon_exp[SW-1:0]));
          accepted++;
        end
      end
    end
  end

  initial begin
    resetn = 1'b0; sck = 1'b0; ws = 1'b1; sd = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_out_left", 48'(out_left), 48'd0);
    check("rst_out_right", 48'(out_right), 48'd0);
    check("rst_overrun", 48'(overrun), 48'd0);
    check("rst_frame_err", 48'(frame_err), 48'd0);
    check("rst_state", 48'(state_dbg), 48'd0);
    resetn = 1'b1;

    // clean frames with out_ready held high
    slot(1'b0, 24'hA5A5A5, 0, 0, LJ_BUILD, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
      frame(24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5);
    end
    #1;
    check("t1_accepted", 48'(accepted), 48'd3);
    check("t1_valid_cycles", 48'(valid_cycles), 48'd3);
    check("t1_queue_empty", 48'(exp_q.size()), 48'd0);
    check("t1_overrun", 48'(overrun), 48'd0);
    check("t1_frame_err", 48'(frame_err), 48'd0);

    // reset in the middle of a right slot, release before its end
    slot(1'b0, 24'h111111, 1, 31, LJ_BUILD, 1'b0);
    slot(1'b1, 24'h222222, 0, 15, LJ_BUILD, 1'b0);
    resetn = 1'b0;
    slot(1'b1, 24'h222222, 16, 19, LJ_BUILD, 1'b0);
    #1;
    check("t2_rst_valid", 48'(out_valid), 48'd0);
    check("t2_rst_state", 48'(state_dbg), 48'd0);
    resetn = 1'b1;
    slot(1'b1, 24'h222222, 20, 31, LJ_BUILD, 1'b0);
    slot(1'b0, 24'h123456, 0, 0, LJ_BUILD, 1'b0);
    exp_q.push_back({24'h123456, 24'h654321});
    frame(24'h123456, 24'h654321, 24'hABCDEF);
    #1;
    check("t2_accepted", 48'(accepted), 48'd4);

    // backpressure: first frame held, second dropped
    out_ready = 1'b0;
    exp_q.push_back({24'hABCDEF, 24'h13579B});
    frame(24'hABCDEF, 24'h13579B, 24'h2468AC);
    #1;
    check("t3_valid_held", 48'(out_valid), 48'd1);
    check("t3_left_first", 48'(out_left), 48'hABCDEF);
    check("t3_no_overrun_yet", 48'(overrun), 48'd0);
    frame(24'h2468AC, 24'hFEDCBA, 24'h0F0F0F);
    #1;
    check("t3_valid_still", 48'(out_valid), 48'd1);
    check("t3_left_kept", 48'(out_left), 48'hABCDEF);
    check("t3_right_kept", 48'(out_right), 48'h13579B);
    check("t3_overrun", 48'(overrun), 48'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t3_valid_cleared", 48'(out_valid), 48'd0);
    check("t3_accepted", 48'(accepted), 48'd5);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("t3_overrun_clr", 48'(overrun), 48'd0);

    // accept in the same cycle as the next completion
    out_ready = 1'b0;
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    exp_q.push_back({24'h3C3C3C, 24'hC3C3C3});
    frame(24'h0F0F0F, 24'hF0F0F0, 24'h3C3C3C);
    #1;
    check("t4_first_loaded", 48'(out_left), 48'h0F0F0F);
    slot(1'b0, 24'h3C3C3C, 1, 31, LJ_BUILD, 1'b0);
    slot(1'b1, 24'hC3C3C3, 0, 31, LJ_BUILD, 1'b0);
    send_bit(1'b0, bitval(24'h777777, 0, LJ_BUILD, 1'b0), 1'b1);
    #1;
    check("t4_valid_kept", 48'(out_valid), 48'd1);
    check("t4_left_new", 48'(out_left), 48'h3C3C3C);
    check("t4_right_new", 48'(out_right), 48'hC3C3C3);
    check("t4_no_overrun", 48'(overrun), 48'd0);
    check("t4_accepted_first", 48'(accepted), 48'd6);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t4_valid_cleared", 48'(out_valid), 48'd0);
    check("t4_accepted", 48'(accepted), 48'd7);

    // short left slot: ws toggles after 16 sck
    slot(1'b0, 24'h777777, 1, 15, LJ_BUILD, 1'b0);
    slot(1'b1, 24'h000000, 0, 0, LJ_BUILD, 1'b0);
    #1;
    check("t5_frame_err", 48'(frame_err), 48'd1);
    check("t5_state_sync", 48'(state_dbg), 48'd0);
    check("t5_no_output", 48'(out_valid), 48'd0);
    slot(1'b1, 24'h000000, 1, 31, LJ_BUILD, 1'b0);
    slot(1'b0, 24'h00FF00, 0, 0, LJ_BUILD, 1'b0);
    #1;
    check("t5_resync_left", 48'(state_dbg), 48'd1);
    exp_q.push_back({24'h00FF00, 24'hFF00FF});
    slot(1'b0, 24'h00FF00, 1, 31, LJ_BUILD, 1'b0);
    slot(1'b1, 24'hFF00FF, 0, 31, LJ_BUILD, 1'b0);

    // left-justified stimulus; the standard build sees it one bit early
    lj_exp = LJ_BUILD ? {24'h800001, 24'h400003} : {24'h000002, 24'h800006};
    exp_q.push_back(lj_exp);
    slot(1'b0, 24'h800001, 0, 31, 1'b1, 1'b1);
    #1;
    check("t5_accepted", 48'(accepted), 48'd8);
    check("t5_err_sticky", 48'(frame_err), 48'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("t5_err_clr", 48'(frame_err), 48'd0);
    slot(1'b1, 24'h400003, 0, 31, 1'b1, 1'b1);
    slot(1'b0, 24'h000000, 0, 0, 1'b1, 1'b1);
    #1;
    check("t6_accepted", 48'(accepted), 48'd9);
    check("end_queue_empty", 48'(exp_q.size()), 48'd0);
    check("end_overrun", 48'(overrun), 48'd0);
    check("end_frame_err", 48'(frame_err), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx_sequencer.md
Name: i2s_rx_sequencer

Overview:
- Receive-side sequencer for the I2S link.
- Runs in the mclk (clk) domain and uses the sck/ws clocks produced by the I2S clock generator: sck period = 8 clk, ws half-period = 256 clk, giving 32 sck per channel slot.
- Frames the serial codec data into stereo sample pairs and hands each completed frame to the visualizer datapath over a valid/ready handshake.
- Reports overrun and framing errors.

Parameters:
- SAMPLE_W, 24, bits captured per channel (MSB-first); legal range 1..31.
- SLOT_W, 32, sck cycles per channel slot; used for framing-error checks.

Ports:
- clk  in  1  mclk, 22.579 MHz.
- resetn  in  1  synchronous, active-low reset.
- sck  in  1  I2S bit clock, synchronous to clk.
- ws  in  1  word select; 0 = left, 1 = right.
- sd  in  1  serial data from the codec.
- out_ready  in  1  consumer accepts the frame.
- err_clr  in  1  single-cycle pulse; clears the sticky error flags.
- out_valid  out  1  frame available.
- out_left  out  SAMPLE_W  left sample.
- out_right  out  SAMPLE_W  right sample.
- overrun  out  1  sticky: a frame was dropped.
- frame_err  out  1  sticky: a slot length other than SLOT_W was seen.

Behaviour:
- Edge detection:
  - sck_d is sck registered once.
  - A "rise cycle" is any clk cycle with sck=1 and sck_d=0.
  - ws and sd are sampled only in rise cycles.
  - ws_prev holds the ws value from the previous rise cycle.
- Bit counter: bit_cnt (6 bits) is set to 0 in a rise cycle where ws != ws_prev; otherwise it increments in each rise cycle, saturating at 63.
- Capture window (I2S one-bit delay):
  - Bit 0 after a ws change is discarded; it is the previous word's LSB slot.
  - Bits 1..SAMPLE_W shift MSB-first into shift_reg.
  - Later bits are ignored.
- State machine:
  - SYNC (reset state): wait for a rise cycle with ws_prev=1 and ws=0, then go to LEFT. Partial frames present before sync are discarded.
  - LEFT: shift left data. On a ws 0->1 rise cycle, latch shift_reg into left_hold and go to RIGHT.
  - RIGHT: shift right data. On a ws 1->0 rise cycle, complete the frame {left_hold, shift_reg} and go to LEFT.
- Framing check:
  - At any ws change in LEFT or RIGHT, bit_cnt must equal SLOT_W-1.
  - Otherwise set frame_err, discard the partial frame and go to SYNC.
  - The same ws edge that triggers the error does not count as a sync edge. Resync requires the next proper 1->0 edge.
- Output handshake:
  - A frame completing in a rise cycle loads out_left/out_right and sets out_valid on the next clk edge, i.e. 1-clk latency.
  - out_valid and the data hold until a cycle with out_valid && out_ready; out_valid then clears on the next edge.
  - Completion while out_valid=1 and out_ready=0: the new frame is dropped, old data is kept, and overrun is set.
  - Completion in the same cycle as an accept: the new frame loads, out_valid stays 1, no overrun.
- err_clr clears overrun and frame_err. If a new error occurs in the same cycle, the set wins.
- Reset values: out_valid=0, out_left=0, out_right=0, overrun=0, frame_err=0, state=SYNC, bit_cnt=0, shift_reg=0, sck_d=0, ws_prev=1.
- Reset asserted mid-frame aborts it immediately; no partial output is ever presented.

Optional Feature:
- Macro: I2S_RX_LJ_FORMAT_EN.
- Defined: left-justified format with no one-bit delay. Bits 0..SAMPLE_W-1 after a ws change are captured, and the SYNC exit condition is unchanged.
- Undefined: standard I2S as described above.

Test Plan:
- Clean frame: counter-driven sck/ws, sd encodes left=0xA5A5A5 and right=0x5A5A5A, out_ready=1 -> after sync, out_valid pulses 1 clk per frame (every 512 clk) with exactly those values; overrun=0 and frame_err=0.
- Reset release mid-right slot -> first partial frame is not output; first out_valid carries the first full frame, 0x123456/0x654321.
- Backpressure: out_ready=0 for 2 frames -> first frame held stable, second dropped, overrun=1; then out_ready=1 -> first frame accepted, out_valid=0 until the next frame.
- Accept coincident with completion: out_ready pulsed in the completion cycle -> out_valid stays high, data updates to the new frame, overrun stays 0.
- Framing error: ws toggled after 16 sck in LEFT -> frame_err=1 and no output. Output resumes after the next valid 1->0 edge; err_clr -> frame_err=0.
- I2S_RX_LJ_FORMAT_EN defined, sd driven left-justified with left=0x800001 -> out_left=0x800001; the same stimulus without the macro yields a value shifted by one bit.
